// File: rtl/bram_access_sequencer.sv
// bram_access_sequencer: job-level sequencer for bram_controller (read phase, result wait, write-back).
// Define BRAM_SEQ_WATCHDOG_EN to add a WAIT_RESULT/WRITE watchdog with a sticky error_o output.
module bram_access_sequencer #(
   parameter int unsigned READ_BEATS            = 64,
   parameter int unsigned READER_DATA_OUT_WIDTH = 8,
   parameter int unsigned WRITER_DATA_IN_WIDTH  = 512,
   parameter int unsigned CNT_WIDTH             = 16,
   parameter int unsigned TIMEOUT_CYCLES        = 4096
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic                             start_i,
   input  logic                             abort_i,
   output logic                             busy_o,
   output logic                             done_o,
   output logic                             rd_en_o,
   input  logic                             rd_valid_i,
   input  logic [READER_DATA_OUT_WIDTH-1:0] rd_data_i,
   output logic                             stream_valid_o,
   output logic [READER_DATA_OUT_WIDTH-1:0] stream_data_o,
   input  logic                             result_valid_i,
   input  logic [WRITER_DATA_IN_WIDTH-1:0]  result_data_i,
   output logic                             wr_en_o,
   output logic                             wr_valid_o,
   output logic [WRITER_DATA_IN_WIDTH-1:0]  wr_data_o,
   input  logic                             wr_finish_i,
   output logic [CNT_WIDTH-1:0]             beat_count_o
`ifdef BRAM_SEQ_WATCHDOG_EN
   ,
   output logic                             error_o
`endif
);

   localparam logic [2:0] S_IDLE        = 3'd0;
   localparam logic [2:0] S_READ        = 3'd1;
   localparam logic [2:0] S_WAIT_RESULT = 3'd2;
   localparam logic [2:0] S_WR_LOAD     = 3'd3;
   localparam logic [2:0] S_WRITE       = 3'd4;
   localparam logic [2:0] S_DONE        = 3'd5;

   logic [2:0] state_q, state_d;
   logic       pending_q, pending_d;
   logic       busy_d, done_d, rd_en_d, wr_en_d, wr_valid_d;
   logic       start_fire_c, beat_fire_c, capture_c, last_beat_c;

   assign start_fire_c = (state_q == S_IDLE) && start_i;
   assign beat_fire_c  = (state_q == S_READ) && rd_valid_i && !abort_i;
   assign capture_c    = ((state_q == S_READ) || (state_q == S_WAIT_RESULT))
                         && result_valid_i && !abort_i;
   assign last_beat_c  = beat_count_o == CNT_WIDTH'(READ_BEATS - 1);

`ifdef BRAM_SEQ_WATCHDOG_EN
   localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [WD_W-1:0] wd_cnt_q;
   logic            wd_expired_c;
   logic            error_d;

   assign wd_expired_c = ((state_q == S_WAIT_RESULT) || (state_q == S_WRITE))
                         && (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1));
`else
   logic unused_timeout;
   assign unused_timeout = ^32'(TIMEOUT_CYCLES);
`endif

   // Next state and next registered outputs; abort overrides everything.
   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
`ifdef BRAM_SEQ_WATCHDOG_EN
      error_d   = error_o;
`endif
      case (state_q)
         S_IDLE:        if (start_i) state_d = S_READ;
         S_READ:        if (rd_valid_i && last_beat_c) state_d = S_WAIT_RESULT;
         S_WAIT_RESULT: if (result_valid_i || pending_q) state_d = S_WR_LOAD;
         S_WR_LOAD:     state_d = S_WRITE;
         S_WRITE:       if (wr_finish_i) state_d = S_DONE;
         S_DONE:        state_d = S_IDLE;
         default:       state_d = S_IDLE;
      endcase
`ifdef BRAM_SEQ_WATCHDOG_EN
      if (start_fire_c) error_d = 1'b0;
      if (wd_expired_c && !abort_i) begin
         state_d = S_IDLE;
         error_d = 1'b1;
      end
`endif
      if (abort_i && (state_q != S_IDLE)) state_d = S_IDLE;

      if ((state_q == S_READ) && capture_c) pending_d = 1'b1;
      if ((state_d == S_IDLE) || (state_d == S_WR_LOAD)) pending_d = 1'b0;

      busy_d     = state_d != S_IDLE;
      done_d     = state_d == S_DONE;
      rd_en_d    = state_d == S_READ;
      wr_en_d    = (state_d == S_WR_LOAD) || (state_d == S_WRITE);
      wr_valid_d = state_d == S_WR_LOAD;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q    <= S_IDLE;
         pending_q  <= 1'b0;
         busy_o     <= 1'b0;
         done_o     <= 1'b0;
         rd_en_o    <= 1'b0;
         wr_en_o    <= 1'b0;
         wr_valid_o <= 1'b0;
      end else begin
         state_q    <= state_d;
         pending_q  <= pending_d;
         busy_o     <= busy_d;
         done_o     <= done_d;
         rd_en_o    <= rd_en_d;
         wr_en_o    <= wr_en_d;
         wr_valid_o <= wr_valid_d;
      end
   end

   // Read-beat forwarding, beat counting and result latch.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         stream_valid_o <= 1'b0;
         stream_data_o  <= '0;
         beat_count_o   <= '0;
         wr_data_o      <= '0;
      end else begin
         stream_valid_o <= beat_fire_c;
         if (beat_fire_c) stream_data_o <= rd_data_i;
         if (start_fire_c) beat_count_o <= '0;
         else if (beat_fire_c) beat_count_o <= beat_count_o + CNT_WIDTH'(1);
         if (capture_c) wr_data_o <= result_data_i;
      end
   end

`ifdef BRAM_SEQ_WATCHDOG_EN
   // Watchdog restarts on every state entry and only runs while waiting on an external agent.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         wd_cnt_q <= '0;
         error_o  <= 1'b0;
      end else begin
         error_o <= error_d;
         if ((state_d == state_q) && ((state_q == S_WAIT_RESULT) || (state_q == S_WRITE)))
            wd_cnt_q <= wd_cnt_q + WD_W'(1);
         else
            wd_cnt_q <= '0;
      end
   end
`endif

endmodule

// File: tb/tb_bram_access_sequencer.sv
// Directed testbench for bram_access_sequencer with READ_BEATS=4 (watchdog scenario when BRAM_SEQ_WATCHDOG_EN is defined).
module tb_bram_access_sequencer;

   localparam int unsigned RB = 4;
   localparam int unsigned RW = 8;
   localparam int unsigned WW = 512;
   localparam int unsigned CW = 16;
   localparam int unsigned TO = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start_i, abort_i, busy_o, done_o, rd_en_o, rd_valid_i;
   logic [RW-1:0] rd_data_i, stream_data_o;
   logic          stream_valid_o, result_valid_i, wr_en_o, wr_valid_o, wr_finish_i;
   logic [WW-1:0] result_data_i, wr_data_o;
   logic [CW-1:0] beat_count_o;
`ifdef BRAM_SEQ_WATCHDOG_EN
   logic          error_o;
`endif

   int checks = 0;
   int passed = 0;
   logic prev_rd_en = 1'b0;

   always #5 clk = ~clk;

   bram_access_sequencer #(
      .READ_BEATS(RB), .READER_DATA_OUT_WIDTH(RW), .WRITER_DATA_IN_WIDTH(WW),
      .CNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk_i(clk), .rst_i(rst_n), .start_i(start_i), .abort_i(abort_i),
      .busy_o(busy_o), .done_o(done_o), .rd_en_o(rd_en_o),
      .rd_valid_i(rd_valid_i), .rd_data_i(rd_data_i),
      .stream_valid_o(stream_valid_o), .stream_data_o(stream_data_o),
      .result_valid_i(result_valid_i), .result_data_i(result_data_i),
      .wr_en_o(wr_en_o), .wr_valid_o(wr_valid_o), .wr_data_o(wr_data_o),
      .wr_finish_i(wr_finish_i), .beat_count_o(beat_count_o)
`ifdef BRAM_SEQ_WATCHDOG_EN
      , .error_o(error_o)
`endif
   );

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic start_job();
      start_i = 1'b1; tick(); start_i = 1'b0;
   endtask

   task automatic drive_beats(input int n, input logic [RW-1:0] base);
      for (int i = 0; i < n; i++) begin
         rd_valid_i = 1'b1; rd_data_i = base + RW'(i); tick();
      end
      rd_valid_i = 1'b0; rd_data_i = '0;
   endtask

   // From the WR_LOAD cycle: one WRITE cycle, then finish so the next cycle is DONE.
   task automatic finish_write();
      tick(); wr_finish_i = 1'b1; tick(); wr_finish_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start_i = 0; abort_i = 0; rd_valid_i = 0; rd_data_i = '0;
      result_valid_i = 0; result_data_i = '0; wr_finish_i = 0;
      #12;
      checks++; if ({busy_o, done_o, rd_en_o, wr_en_o, wr_valid_o, stream_valid_o} !== 6'b0)
         $display("FAIL reset_ctrl got=%b exp=000000", {busy_o, done_o, rd_en_o, wr_en_o, wr_valid_o, stream_valid_o}); else passed++;
      checks++; if (beat_count_o !== '0 || wr_data_o !== '0)
         $display("FAIL reset_data beat_count=%0d wr_data_nonzero=%b exp 0", beat_count_o, |wr_data_o); else passed++;
      tick(); rst_n = 1'b1; tick();
   endtask

   task automatic test_nominal();
      logic [RW-1:0] b [4];
      logic [WW-1:0] res;
      int wv, dn;
      b[0] = 8'h11; b[1] = 8'h22; b[2] = 8'h33; b[3] = 8'h44;
      res = {64{8'hA5}};
      start_job();
      checks++; if (busy_o !== 1'b1 || rd_en_o !== 1'b1 || beat_count_o !== '0)
         $display("FAIL nom_start busy=%b rd_en=%b cnt=%0d exp 1 1 0", busy_o, rd_en_o, beat_count_o); else passed++;
      for (int i = 0; i < 4; i++) begin
         rd_valid_i = 1'b1; rd_data_i = b[i]; tick();
         checks++; if (stream_valid_o !== 1'b1 || stream_data_o !== b[i])
            $display("FAIL nom_stream%0d valid=%b data=%h exp 1 %h", i, stream_valid_o, stream_data_o, b[i]); else passed++;
         checks++; if (beat_count_o !== CW'(i + 1) || rd_en_o !== (i < 3))
            $display("FAIL nom_count%0d cnt=%0d rd_en=%b exp %0d %b", i, beat_count_o, rd_en_o, i + 1, i < 3); else passed++;
      end
      rd_valid_i = 1'b0; tick();
      checks++; if (stream_valid_o !== 1'b0 || rd_en_o !== 1'b0 || wr_en_o !== 1'b0)
         $display("FAIL nom_wait sv=%b rd_en=%b wr_en=%b exp 000", stream_valid_o, rd_en_o, wr_en_o); else passed++;
      result_valid_i = 1'b1; result_data_i = res; tick(); result_valid_i = 1'b0; result_data_i = '0;
      checks++; if (wr_valid_o !== 1'b1 || wr_en_o !== 1'b1 || wr_data_o !== res)
         $display("FAIL nom_wrload wv=%b we=%b data_ok=%b exp 1 1 1", wr_valid_o, wr_en_o, wr_data_o === res); else passed++;
      wv = 0; dn = 0;
      repeat (15) begin tick(); wv += int'(wr_valid_o); dn += int'(done_o); end
      checks++; if (wv != 0 || dn != 0 || wr_en_o !== 1'b1 || wr_data_o !== res)
         $display("FAIL nom_write extra_wv=%0d done=%0d we=%b exp 0 0 1", wv, dn, wr_en_o); else passed++;
      wr_finish_i = 1'b1; tick(); wr_finish_i = 1'b0;
      checks++; if (done_o !== 1'b1 || wr_en_o !== 1'b0 || busy_o !== 1'b1)
         $display("FAIL nom_done done=%b we=%b busy=%b exp 1 0 1", done_o, wr_en_o, busy_o); else passed++;
      tick();
      checks++; if (done_o !== 1'b0 || busy_o !== 1'b0 || beat_count_o !== CW'(4))
         $display("FAIL nom_idle done=%b busy=%b cnt=%0d exp 0 0 4", done_o, busy_o, beat_count_o); else passed++;
   endtask

   task automatic test_early_result();
      logic [WW-1:0] early;
      early = {16{32'hC0DE_0001}};
      start_job();
      for (int i = 0; i < 4; i++) begin
         rd_valid_i = 1'b1; rd_data_i = RW'(i);
         if (i == 1) begin result_valid_i = 1'b1; result_data_i = early; end
         tick(); result_valid_i = 1'b0; result_data_i = '0;
      end
      rd_valid_i = 1'b0;
      checks++; if (wr_valid_o !== 1'b0 || wr_en_o !== 1'b0 || rd_en_o !== 1'b0)
         $display("FAIL early_wait wv=%b we=%b re=%b exp 000", wr_valid_o, wr_en_o, rd_en_o); else passed++;
      tick();
      checks++; if (wr_valid_o !== 1'b1 || wr_data_o !== early)
         $display("FAIL early_wrload wv=%b data_ok=%b exp 1 1", wr_valid_o, wr_data_o === early); else passed++;
      finish_write();
      checks++; if (done_o !== 1'b1)
         $display("FAIL early_done done=%b exp 1", done_o); else passed++;
      tick();
   endtask

   task automatic test_reset_mid_job();
      start_job();
      drive_beats(2, 8'h50);
      result_valid_i = 1'b1; result_data_i = {16{32'h1234_5678}}; tick();
      result_valid_i = 1'b0; result_data_i = '0;
      rst_n = 1'b0; #1;
      checks++; if (busy_o !== 1'b0 || rd_en_o !== 1'b0 || beat_count_o !== '0 || wr_data_o !== '0 || stream_valid_o !== 1'b0)
         $display("FAIL reset_mid busy=%b re=%b cnt=%0d wd_nz=%b exp 0 0 0 0", busy_o, rd_en_o, beat_count_o, |wr_data_o); else passed++;
      tick(); rst_n = 1'b1; tick();
   endtask

   task automatic test_abort();
      int dn;
      start_job();
      drive_beats(4, 8'h60);
      result_valid_i = 1'b1; result_data_i = {64{8'h3C}}; tick();
      result_valid_i = 1'b0; result_data_i = '0;
      tick(); tick(); tick();
      checks++; if (wr_en_o !== 1'b1)
         $display("FAIL abort_pre we=%b exp 1", wr_en_o); else passed++;
      abort_i = 1'b1; tick(); abort_i = 1'b0;
      checks++; if (busy_o !== 1'b0 || wr_en_o !== 1'b0 || wr_valid_o !== 1'b0 || done_o !== 1'b0)
         $display("FAIL abort_idle busy=%b we=%b wv=%b done=%b exp 0000", busy_o, wr_en_o, wr_valid_o, done_o); else passed++;
      dn = 0;
      repeat (3) begin tick(); dn += int'(done_o); end
      checks++; if (dn != 0)
         $display("FAIL abort_nodone done_pulses=%0d exp 0", dn); else passed++;
      start_job();
      checks++; if (beat_count_o !== '0 || rd_en_o !== 1'b1)
         $display("FAIL abort_restart cnt=%0d re=%b exp 0 1", beat_count_o, rd_en_o); else passed++;
      drive_beats(4, 8'h70);
      result_valid_i = 1'b1; result_data_i = {64{8'h5A}}; tick();
      result_valid_i = 1'b0; result_data_i = '0;
      finish_write();
      checks++; if (done_o !== 1'b1 || beat_count_o !== CW'(4) || wr_data_o !== {64{8'h5A}})
         $display("FAIL abort_rerun done=%b cnt=%0d exp 1 4", done_o, beat_count_o); else passed++;
      tick();
   endtask

   task automatic test_ignored_inputs();
      int dn;
      start_job();
      drive_beats(1, 8'h80);
      start_i = 1'b1; wr_finish_i = 1'b1; tick(); start_i = 1'b0; wr_finish_i = 1'b0;
      checks++; if (rd_en_o !== 1'b1 || busy_o !== 1'b1 || done_o !== 1'b0 || beat_count_o !== CW'(1))
         $display("FAIL ign_read re=%b busy=%b done=%b cnt=%0d exp 1 1 0 1", rd_en_o, busy_o, done_o, beat_count_o); else passed++;
      drive_beats(3, 8'h81);
      rd_valid_i = 1'b1; rd_data_i = 8'hEE; tick(); rd_valid_i = 1'b0;
      checks++; if (stream_valid_o !== 1'b0 || beat_count_o !== CW'(4))
         $display("FAIL ign_wait_beat sv=%b cnt=%0d exp 0 4", stream_valid_o, beat_count_o); else passed++;
      result_valid_i = 1'b1; result_data_i = {64{8'h99}}; tick();
      result_valid_i = 1'b0; result_data_i = '0;
      finish_write();
      checks++; if (done_o !== 1'b1)
         $display("FAIL ign_done done=%b exp 1", done_o); else passed++;
      dn = 0;
      rd_valid_i = 1'b1; wr_finish_i = 1'b1;
      repeat (5) begin tick(); dn += int'(done_o); end
      rd_valid_i = 1'b0; wr_finish_i = 1'b0;
      checks++; if (dn != 0 || busy_o !== 1'b0 || stream_valid_o !== 1'b0 || beat_count_o !== CW'(4))
         $display("FAIL ign_idle done=%0d busy=%b sv=%b cnt=%0d exp 0 0 0 4", dn, busy_o, stream_valid_o, beat_count_o); else passed++;
   endtask

   task automatic random_cycle();
      tick();
      checks++; if ((rd_en_o & wr_en_o) !== 1'b0)
         $display("FAIL rnd_excl re=%b we=%b", rd_en_o, wr_en_o); else passed++;
      checks++; if ((wr_valid_o & ~wr_en_o) !== 1'b0)
         $display("FAIL rnd_wv_no_we wv=%b we=%b", wr_valid_o, wr_en_o); else passed++;
      checks++; if ((wr_en_o & prev_rd_en) !== 1'b0)
         $display("FAIL rnd_dead_cycle prev_re=%b we=%b", prev_rd_en, wr_en_o); else passed++;
      prev_rd_en = rd_en_o;
   endtask

   task automatic test_random_jobs();
      logic [WW-1:0] exp_data;
      int sent, guard, got, d;
      for (int j = 0; j < 100; j++) begin
         exp_data = '0; got = 0; sent = 0; guard = 0;
         start_i = 1'b1; random_cycle(); start_i = 1'b0;
         while (sent < int'(RB) && guard < 200) begin
            rd_valid_i = 1'($urandom_range(0, 1)); rd_data_i = RW'($urandom);
            if ($urandom_range(0, 3) == 0) begin
               result_valid_i = 1'b1;
               for (int k = 0; k < 16; k++) result_data_i[k*32 +: 32] = $urandom;
               exp_data = result_data_i;
               got = 1;
            end
            random_cycle();
            if (rd_valid_i) sent++;
            rd_valid_i = 1'b0; result_valid_i = 1'b0; guard++;
         end
         checks++; if (beat_count_o !== CW'(RB))
            $display("FAIL rnd_count job=%0d cnt=%0d exp %0d", j, beat_count_o, RB); else passed++;
         d = (got != 0) ? -1 : int'($urandom_range(0, 3));
         got = 0;
         for (int c = 0; c < 10 && got == 0; c++) begin
            if (c == d) begin
               result_valid_i = 1'b1;
               for (int k = 0; k < 16; k++) result_data_i[k*32 +: 32] = $urandom;
               exp_data = result_data_i;
            end
            rd_valid_i = 1'($urandom_range(0, 1));
            random_cycle();
            result_valid_i = 1'b0; rd_valid_i = 1'b0;
            if (wr_valid_o) got = 1;
         end
         checks++; if (got != 1 || wr_data_o !== exp_data)
            $display("FAIL rnd_wrload job=%0d seen=%0d data_ok=%b", j, got, wr_data_o === exp_data); else passed++;
         random_cycle();
         repeat ($urandom_range(0, 4)) random_cycle();
         wr_finish_i = 1'b1; random_cycle(); wr_finish_i = 1'b0;
         checks++; if (done_o !== 1'b1)
            $display("FAIL rnd_done job=%0d done=%b exp 1", j, done_o); else passed++;
         random_cycle();
         checks++; if (busy_o !== 1'b0 || done_o !== 1'b0)
            $display("FAIL rnd_idle job=%0d busy=%b done=%b exp 0 0", j, busy_o, done_o); else passed++;
      end
   endtask

`ifdef BRAM_SEQ_WATCHDOG_EN
   task automatic test_watchdog();
      start_job();
      drive_beats(4, 8'hA0);
      repeat (TO - 1) tick();
      checks++; if (error_o !== 1'b0 || busy_o !== 1'b1)
         $display("FAIL wd_before err=%b busy=%b exp 0 1", error_o, busy_o); else passed++;
      tick();
      checks++; if (error_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0)
         $display("FAIL wd_fire err=%b busy=%b done=%b exp 1 0 0", error_o, busy_o, done_o); else passed++;
      repeat (3) tick();
      checks++; if (error_o !== 1'b1)
         $display("FAIL wd_sticky err=%b exp 1", error_o); else passed++;
      start_job();
      checks++; if (error_o !== 1'b0 || busy_o !== 1'b1)
         $display("FAIL wd_clear err=%b busy=%b exp 0 1", error_o, busy_o); else passed++;
      abort_i = 1'b1; tick(); abort_i = 1'b0; tick();
   endtask
`endif

   initial begin
      test_reset();
      test_nominal();
      test_early_result();
      test_reset_mid_job();
      test_abort();
      test_ignored_inputs();
      test_random_jobs();
`ifdef BRAM_SEQ_WATCHDOG_EN
      test_watchdog();
`endif
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/bram_access_sequencer.md
Name: bram_access_sequencer

Overview:
- Job-level sequencer for bram_controller: starts the read phase, counts streamed read beats, and waits for the compute result.
- Then runs the write-back phase and waits for the writer's finish.
- Sole driver of the controller's rd_en_i/wr_en_i/wr_valid_i/wr_data_i; forwards read bytes to the compute datapath and reports done/busy to the top-level control.

Parameters:
- READ_BEATS, 64, valid read beats consumed per job (>=2)
- READER_DATA_OUT_WIDTH, 8, width of read beat from controller
- WRITER_DATA_IN_WIDTH, 512, width of result vector written back
- CNT_WIDTH, 16, width of beat counter (2^CNT_WIDTH > READ_BEATS)
- TIMEOUT_CYCLES, 4096, watchdog limit (used only with optional feature)

Ports:
- clk_i  in  1  clock; all logic rising-edge
- rst_i  in  1  reset, asynchronous, active-low
- start_i  in  1  job request pulse; honoured only in IDLE
- abort_i  in  1  synchronous abort; returns to IDLE
- busy_o  out  1  high in any state except IDLE
- done_o  out  1  one-cycle pulse on job completion
- rd_en_o  out  1  to controller rd_en_i
- rd_valid_i  in  1  from controller rd_valid_o
- rd_data_i  in  READER_DATA_OUT_WIDTH  from controller rd_data_o
- stream_valid_o  out  1  registered forward of counted read beats
- stream_data_o  out  READER_DATA_OUT_WIDTH  registered read byte
- result_valid_i  in  1  compute result strobe
- result_data_i  in  WRITER_DATA_IN_WIDTH  compute result
- wr_en_o  out  1  to controller wr_en_i
- wr_valid_o  out  1  to controller wr_valid_i
- wr_data_o  out  WRITER_DATA_IN_WIDTH  latched result to controller wr_data_i
- wr_finish_i  in  1  from controller wr_finish_o
- beat_count_o  out  CNT_WIDTH  read beats accepted in current job

Behaviour:
- Reset (rst_i=0, async): state IDLE; all outputs 0, including wr_data_o, beat_count_o and the result-pending flag.
- States: IDLE, READ, WAIT_RESULT, WR_LOAD, WRITE, DONE.
- IDLE:
  - start_i=1 -> READ next cycle.
  - beat_count_o cleared and pending flag cleared on that transition.
- READ:
  - rd_en_o=1.
  - Each cycle with rd_valid_i=1: beat_count_o += 1; the next cycle stream_valid_o=1 and stream_data_o=rd_data_i (1-cycle latency).
  - The beat taking the count to READ_BEATS -> WAIT_RESULT; rd_en_o low from the next cycle.
  - rd_valid_i outside READ is ignored: not counted, not forwarded.
- WAIT_RESULT:
  - Minimum 1 cycle; rd_en_o=wr_en_o=0, which guarantees a dead cycle between read and write ownership.
  - On result_valid_i=1, or if the pending flag is set -> WR_LOAD.
- Result capture:
  - result_data_i is latched into wr_data_o on any result_valid_i while in READ or WAIT_RESULT.
  - A capture in READ sets the pending flag.
  - Later strobes before WR_LOAD overwrite: last one wins.
- WR_LOAD: exactly one cycle; wr_en_o=1, wr_valid_o=1 -> WRITE.
- WRITE:
  - wr_en_o=1, wr_valid_o=0; wr_data_o held stable.
  - wr_finish_i=1 -> DONE.
  - A wr_finish_i seen in any other state is ignored.
- DONE: done_o=1 for one cycle; wr_en_o=0 -> IDLE. busy_o falls the cycle after done_o.
- Invariants:
  - rd_en_o & wr_en_o is never 1.
  - wr_valid_o only when wr_en_o.
  - done_o is never asserted on an aborted job.
- start_i while busy: ignored, with no queuing.
- abort_i=1 in any non-IDLE state: next cycle IDLE, all enables 0, pending cleared, no done_o. abort_i has priority over every other transition in the same cycle.
- Reset mid-job: immediate IDLE, all outputs 0. The controller's own reset handles its internal state.
- beat_count_o holds its final value until the next start.

Optional Feature:
- Macro BRAM_SEQ_WATCHDOG_EN.
- With it defined:
  - Adds output error_o (1 bit, sticky) and a cycle counter that runs in WAIT_RESULT and WRITE and clears on each state entry.
  - When the counter reaches TIMEOUT_CYCLES: error_o=1, state -> IDLE, enables dropped, no done_o.
  - error_o is cleared only by reset or by an accepted start_i.
- Without it: no error_o port and no counter; the FSM waits indefinitely in WAIT_RESULT and WRITE.

Test Plan:
- Nominal job:
  - Stimulus: READ_BEATS=4; start_i pulse; 4 rd_valid_i beats with bytes 0x11,0x22,0x33,0x44; result_valid_i two cycles later with data 0xA5 repeated; wr_finish_i 16 cycles after wr_valid_o.
  - Required: stream_data_o 0x11..0x44, each 1 cycle after its input; rd_en_o falls after beat 4; wr_valid_o is a single pulse with wr_data_o=0xA5..; done_o single pulse; beat_count_o=4.
- Early result: result_valid_i during beat 2 of READ -> WR_LOAD follows exactly 1 WAIT_RESULT cycle after the last beat; wr_data_o equals the early value.
- Mutual exclusion and dead cycle: over 100 random jobs, rd_en_o & wr_en_o always 0, and at least 1 cycle with both low between the phases.
- Abort: abort_i asserted 3 cycles into WRITE -> IDLE next cycle; wr_en_o=0; no done_o; a new start_i then runs a clean job with beat_count_o restarting at 0.
- Ignored inputs: start_i during READ, and wr_finish_i during READ -> no state change, no extra job, no done_o.
- Watchdog (BRAM_SEQ_WATCHDOG_EN, TIMEOUT_CYCLES=32): no result_valid_i -> error_o=1 at cycle 32 of WAIT_RESULT, busy_o=0, no done_o; the next start_i clears error_o.
